// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Read-side engine for a show-ahead (ack-style) FIFO. Pops head
//            words with fifo_deq, stages each one until its "last" flag is
//            known, then forwards it to a registered valid/ready stream.
//            Words are grouped into bursts of BURST_LEN; a partial burst is
//            closed when the FIFO stays empty for TIMEOUT cycles or on flush.
// Ports    : clk, rst (async, active-high)
//            fifo_data_out / fifo_rdempty / fifo_deq : FIFO read side
//            flush                                   : close staged word now
//            out_data / out_valid / out_last / out_ready : output stream
//            bursts_done                             : completed bursts (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_data_out,
    input  logic             fifo_rdempty,
    output logic             fifo_deq,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [7:0]       bursts_done
);

    localparam int IW = $clog2(BURST_LEN + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] c_ONE_IDX     = IW'(1);
    localparam logic [IW-1:0] c_LAST_IDX    = IW'(BURST_LEN);
    localparam logic [CW-1:0] c_TIMEOUT_CNT = CW'(TIMEOUT);

    // Stage register: one word waiting for its last flag to be decided.
    logic             r_stage_valid;
    logic [WIDTH-1:0] r_stage_data;
    logic [IW-1:0]    r_stage_idx;   // 1-based position of staged word
    logic [IW-1:0]    r_next_idx;    // position the next popped word takes
    logic [CW-1:0]    r_idle_cnt;    // empty cycles seen while a word is staged

    logic             w_last;
    logic             w_last_known;
    logic             w_out_free;
    logic             w_move;
    logic             w_pop;
    logic [IW-1:0]    w_after_idx;

    // The staged word is definitely last on a full burst, a timeout or a
    // flush. It is definitely not last when another word is already waiting
    // at the FIFO head. Otherwise it must stay staged until one of those
    // becomes true. The IDLE / WAIT / SEND sequencing falls out of these
    // terms directly, so no separate state register is kept.
    assign w_last       = (r_stage_idx == c_LAST_IDX) ||
                          (r_idle_cnt == c_TIMEOUT_CNT) || flush;
    assign w_last_known = w_last || !fifo_rdempty;
    assign w_out_free   = !out_valid || out_ready;
    assign w_move       = r_stage_valid && w_out_free && w_last_known;

    // Pop whenever the stage is empty or is being emptied this cycle; gated
    // by rst so no word is acknowledged while the engine is being cleared.
    assign w_pop        = !rst && !fifo_rdempty && (!r_stage_valid || w_move);
    assign fifo_deq     = w_pop;

    // Position that follows the word leaving the stage.
    assign w_after_idx  = w_last ? c_ONE_IDX : (r_stage_idx + c_ONE_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
            r_stage_idx   <= '0;
            r_next_idx    <= c_ONE_IDX;
            r_idle_cnt    <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            bursts_done   <= 8'd0;
        end else begin
            // Stage refill / drain. A pop in the same cycle as a move takes
            // its position from the word just moved; a pop into an empty
            // stage uses the position remembered from the last move.
            if (w_pop) begin
                r_stage_valid <= 1'b1;
                r_stage_data  <= fifo_data_out;
                r_stage_idx   <= w_move ? w_after_idx : r_next_idx;
            end else if (w_move) begin
                r_stage_valid <= 1'b0;
            end

            if (w_move) begin
                r_next_idx <= w_after_idx;
            end

            // Timeout counter only runs while a word sits staged with an
            // empty FIFO behind it; it saturates at TIMEOUT.
            if (!r_stage_valid || !fifo_rdempty || w_move) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_TIMEOUT_CNT) begin
                r_idle_cnt <= r_idle_cnt + CW'(1);
            end

            // Output register: load on move, otherwise clear on handshake.
            if (w_move) begin
                out_data  <= r_stage_data;
                out_last  <= w_last;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (out_valid && out_ready && out_last) begin
                bursts_done <= bursts_done + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Self-checking bench for fifo_burst_reader. A show-ahead FIFO
//            model feeds the DUT; each pushed group of words is expanded into
//            expected (data, last) pairs which a monitor pops and compares on
//            every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int WIDTH = 4;
    localparam int BL    = 4;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_rdempty;
    logic             fifo_deq;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic [7:0]       bursts_done;

    fifo_burst_reader #(.WIDTH(WIDTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_data_out (fifo_data_out),
        .fifo_rdempty  (fifo_rdempty),
        .fifo_deq      (fifo_deq),
        .flush         (flush),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .bursts_done   (bursts_done)
    );

    always #5 clk = ~clk;

    // ---------------- show-ahead FIFO model ----------------
    logic [WIDTH-1:0] fmem [0:1023];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_rdempty  = (rd_ptr == wr_ptr);
    assign fifo_data_out = fmem[rd_ptr % 1024];

    initial forever begin
        @(posedge clk);
        if (fifo_deq) rd_ptr <= rd_ptr + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] bd_exp = 8'd0;
    int         ready_mode = 1;   // 0 stall, 1 ready, 2 random, 3 toggle

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream of a group: every group ends on a last (closed by
    // timeout or flush before the next group is pushed), and within a group
    // every BL-th word is a last. The first `pre` words are already in the
    // FIFO and are only added to the model.
    task automatic push_group(input logic [WIDTH-1:0] ws[$], input int pre);
        exp_t e;
        for (int i = 0; i < ws.size(); i++) begin
            if (i >= pre) begin
                fmem[wr_ptr % 1024] = ws[i];
                wr_ptr++;
            end
            e.d = ws[i];
            e.l = (((i + 1) % BL) == 0) || (i == ws.size() - 1);
            sb.push_back(e);
            if (e.l) bd_exp = bd_exp + 8'd1;
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int k, output int n);
        int seen;
        seen = 0;
        n = 0;
        while (seen < k && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid && out_ready) seen++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || rd_ptr != wr_ptr) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_bound"}, int'(n < 300), 1);
        repeat (4) @(negedge clk);
        chk({name, "_idle_valid"}, out_valid, 0);
        chk({name, "_bursts_done"}, bursts_done, bd_exp);
    endtask

    // ---------------- ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ~out_ready;
        endcase
    end

    // ---------------- monitor ----------------
    initial begin
        logic             prev_stall;
        logic [WIDTH-1:0] prev_d;
        logic             prev_l;
        exp_t             e;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_fifo_deq", fifo_deq, 0);
                chk("rst_bursts_done", bursts_done, 0);
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, prev_d);
                    chk("hold_last", out_last, prev_l);
                end
                if (fifo_rdempty) chk("deq_when_empty", fifo_deq, 0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got data %0d last %0d expected none", out_data, out_last);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_last", out_last, e.l);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                prev_l     = out_last;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] ws[$];
        int n;
        int w;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        align();
        rst = 1'b0;

        // Reset mid-burst: one word popped, then reset discards it.
        align();
        ws = '{4'd6, 4'd7};
        for (int i = 0; i < 2; i++) begin
            fmem[wr_ptr % 1024] = ws[i];
            wr_ptr++;
        end
        align();
        rst = 1'b1;
        chk("t1_one_pop", rd_ptr, 1);
        repeat (2) @(negedge clk);
        align();
        rst = 1'b0;
        sb.delete();
        bd_exp = 8'd0;
        // 7 is still in the FIFO; with 1,2,3 it forms a fresh burst of 4.
        ws = '{4'd7, 4'd1, 4'd2, 4'd3};
        push_group(ws, 1);
        wait_drain("t1");

        // Full burst then timeout-closed partial burst.
        align();
        ws = '{4'd6, 4'd7, 4'd3, 4'd8, 4'd5};
        push_group(ws, 0);
        wait_hs(5, n);
        chk("t2_timeout_latency", n, TO + 7);
        wait_drain("t2");

        // Exact burst: last with no timeout wait.
        align();
        ws = '{4'd1, 4'd2, 4'd3, 4'd4};
        push_group(ws, 0);
        wait_hs(4, n);
        chk("t3_exact_latency", n, 6);
        wait_drain("t3");

        // Backpressure: only two words held internally.
        ready_mode = 0;
        repeat (2) align();
        ws = '{4'd9, 4'd10, 4'd11, 4'd12};
        push_group(ws, 0);
        w = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_deq) w++;
        end
        chk("t4_pops", w, 2);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 9);
        chk("t4_last", out_last, 0);
        ready_mode = 1;
        wait_drain("t4");

        // Flush two cycles after the pop.
        align();
        ws = '{4'd8};
        push_group(ws, 0);
        fork
            wait_hs(1, n);
            begin
                repeat (3) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        chk("t5_flush_latency", n, 5);
        wait_drain("t5");
        align();
        ws = '{4'd13, 4'd14, 4'd15, 4'd0};
        push_group(ws, 0);
        wait_drain("t5b");

        // Continuous supply with toggling ready: 12 words, 3 bursts.
        ready_mode = 3;
        align();
        ws.delete();
        for (int i = 0; i < 12; i++) ws.push_back(WIDTH'($urandom));
        push_group(ws, 0);
        wait_drain("t6");

        // Random groups, closed by timeout or flush, random ready.
        ready_mode = 2;
        for (int g = 0; g < 30; g++) begin
            align();
            ws.delete();
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) ws.push_back(WIDTH'($urandom));
            push_group(ws, 0);
            if ($urandom_range(0, 1) == 1) begin
                w = 0;
                while (rd_ptr != wr_ptr && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                align();
                flush = 1'b1;
                w = 0;
                while (sb.size() != 0 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                align();
                flush = 1'b0;
            end
            wait_drain("rnd");
        end
        ready_mode = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
